// File: rtl/instr_readout.sv
// Instruction register drain stage. Sweeps a window of register locations,
// recomputes each stored result, and streams the entries out over a
// valid/ready interface with a per-sweep mismatch count.

package instr_readout_pkg;

    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] address_t;

    typedef enum logic [3:0] {
        OPC_ZERO  = 4'd0,
        OPC_PASSA = 4'd1,
        OPC_PASSB = 4'd2,
        OPC_ADD   = 4'd3,
        OPC_SUB   = 4'd4,
        OPC_MULT  = 4'd5,
        OPC_DIV   = 4'd6,
        OPC_MOD   = 4'd7
    } opc_e;

    typedef struct packed {
        logic [3:0]  opc;
        logic [7:0]  op_a;
        logic [7:0]  op_b;
        logic [15:0] res;
    } instruction_t;

    // Signed result at the res width; operands are sign-extended first and
    // a zero divisor yields zero rather than an undefined quotient.
    function automatic logic [15:0] calc_expected(input instruction_t iw);
        logic signed [15:0] a_s;
        logic signed [15:0] b_s;
        logic signed [15:0] r_s;
        a_s = {{8{iw.op_a[7]}}, iw.op_a};
        b_s = {{8{iw.op_b[7]}}, iw.op_b};
        r_s = 16'sd0;
        case (iw.opc)
            OPC_ZERO:  r_s = 16'sd0;
            OPC_PASSA: r_s = a_s;
            OPC_PASSB: r_s = b_s;
            OPC_ADD:   r_s = a_s + b_s;
            OPC_SUB:   r_s = a_s - b_s;
            OPC_MULT:  r_s = a_s * b_s;
            OPC_DIV: begin
                if (b_s == 16'sd0) r_s = 16'sd0;
                else               r_s = a_s / b_s;
            end
            OPC_MOD: begin
                if (b_s == 16'sd0) r_s = 16'sd0;
                else               r_s = a_s % b_s;
            end
            default:   r_s = 16'sd0;
        endcase
        return r_s;
    endfunction

endpackage

module instr_readout
    import instr_readout_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  address_t         start_addr,
    input  logic [CNT_W-1:0] count,
    output address_t         read_pointer,
    input  instruction_t     instruction_word,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output address_t         out_addr,
    output instruction_t     out_iw,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam address_t ADDR_ZERO = {ADDR_W{1'b0}};
    localparam address_t ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam address_t ADDR_LAST = address_t'(DEPTH - 1);

    state_e           state_q, state_d;
    address_t         rp_q, rp_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    address_t         out_addr_q, out_addr_d;
    instruction_t     out_iw_q, out_iw_d;
    logic             out_err_q, out_err_d;
    logic             mismatch_s;
    address_t         rp_next_s;

    assign mismatch_s = (calc_expected(instruction_word) != instruction_word.res);
    assign rp_next_s  = (rp_q == ADDR_LAST) ? ADDR_ZERO : (rp_q + ADDR_ONE);

    // Next-state and output-register logic for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        rp_d        = rp_q;
        remaining_d = remaining_q;
        err_count_d = err_count_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_iw_d    = out_iw_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_count_d = CNT_ZERO;
                    if (count != CNT_ZERO) begin
                        rp_d        = start_addr;
                        remaining_d = count;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                out_iw_d    = instruction_word;
                out_addr_d  = rp_q;
                out_err_d   = mismatch_s;
                out_valid_d = 1'b1;
                if (mismatch_s && (err_count_q != CNT_SAT)) begin
                    err_count_d = err_count_q + CNT_ONE;
                end else begin
                    err_count_d = err_count_q;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        rp_d    = rp_next_s;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rp_q        <= ADDR_ZERO;
            remaining_q <= CNT_ZERO;
            err_count_q <= CNT_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= ADDR_ZERO;
            out_iw_q    <= '{opc: 4'd0, op_a: 8'd0, op_b: 8'd0, res: 16'd0};
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rp_q        <= rp_d;
            remaining_q <= remaining_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_iw_q    <= out_iw_d;
            out_err_q   <= out_err_d;
        end
    end

    assign read_pointer = rp_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_iw       = out_iw_q;
    assign out_err      = out_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_instr_readout.sv
// Scoreboard bench for instr_readout: expected entries are queued when a
// sweep is launched and a negedge monitor pops them on every handshake.

module tb_instr_readout;
    import instr_readout_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    address_t         start_addr;
    logic [CNT_W-1:0] count;
    address_t         read_pointer;
    instruction_t     instruction_word;
    logic             busy, done, out_valid, out_ready, out_err;
    address_t         out_addr;
    instruction_t     out_iw;
    logic [CNT_W-1:0] err_count;

    instruction_t mem [DEPTH];
    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    instr_readout #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .count(count), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_iw(out_iw), .out_err(out_err), .err_count(err_count)
    );

    typedef struct {
        int           addr;
        instruction_t iw;
        bit           err;
    } exp_t;

    exp_t sb_q[$];
    int   done_err_q[$];
    bit   done_ent_q[$];

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int last_hs_cyc = 0;
    bit rnd_ready   = 1'b0;
    bit fixed_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference arithmetic in plain integers, truncated to the res width.
    function automatic logic [15:0] ref_result(input instruction_t iw);
        int a, b, r;
        a = $signed(iw.op_a);
        b = $signed(iw.op_b);
        case (iw.opc)
            4'd0: r = 0;
            4'd1: r = a;
            4'd2: r = b;
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: r = a * b;
            4'd6: r = (b == 0) ? 0 : a / b;
            4'd7: r = (b == 0) ? 0 : a % b;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic instruction_t rand_entry();
        instruction_t e;
        e.opc  = 4'($urandom_range(0, 9));
        e.op_a = 8'($urandom);
        e.op_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        e.res  = 16'd0;
        if ($urandom_range(0, 1) == 0) e.res = ref_result(e);
        else                           e.res = 16'($urandom);
        return e;
    endfunction

    task automatic push_sweep(input int sa, input int cnt);
        int errs = 0;
        for (int i = 0; i < cnt; i++) begin
            exp_t x;
            x.addr = (sa + i) % DEPTH;
            x.iw   = mem[x.addr];
            x.err  = (ref_result(x.iw) != x.iw.res);
            if (x.err && errs < 63) errs++;
            sb_q.push_back(x);
        end
        done_err_q.push_back(errs);
        done_ent_q.push_back(cnt != 0);
    endtask

    task automatic issue_start(input int sa, input int cnt);
        @(posedge clk); #1;
        start = 1'b1; start_addr = address_t'(sa); count = CNT_W'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_sweep(input int cnt);
        int  n = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 400 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; n = i; end
        end
        if (!seen) begin
            fail_now("done_timeout");
        end else begin
            if (cnt == 0) check("zero_count_done_latency", n, 1);
            check("busy_in_done", busy, 1'b1);
            @(negedge clk);
            check("busy_after_done", busy, 1'b0);
            check("done_one_cycle", done, 1'b0);
        end
    endtask

    task automatic run_sweep(input int sa, input int cnt, input bit poke);
        push_sweep(sa, cnt);
        issue_start(sa, cnt);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1; start_addr = address_t'($urandom_range(0, DEPTH - 1)); count = '0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        finish_sweep(cnt);
    endtask

    // Ready driver: random throttling or a fixed level chosen by the sequence.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
        end
    end

    // Monitor: score every handshake and every done pulse.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_entry");
            end else begin
                exp_t x;
                x = sb_q.pop_front();
                check("out_addr", out_addr, x.addr);
                check("out_iw", out_iw, x.iw);
                check("out_err", out_err, x.err);
            end
            last_hs_cyc = cyc;
        end
        if (reset_n && done) begin
            if (done_err_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                int e;
                bit ent;
                e   = done_err_q.pop_front();
                ent = done_ent_q.pop_front();
                check("err_count_at_done", err_count, e);
                check("entries_drained", sb_q.size(), 0);
                if (ent) check("done_after_last_handshake", cyc - last_hs_cyc, 1);
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '{opc: 4'd0, op_a: 8'd0, op_b: 8'd0, res: 16'd0};
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_iw", out_iw, 0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_err_count", err_count, 0);
        check("rst_read_pointer", read_pointer, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        fixed_ready = 1'b1;

        // Basic arithmetic, all matching.
        mem[0] = '{opc: 4'd3, op_a: 8'd5,   op_b: 8'd3, res: 16'd8};
        mem[1] = '{opc: 4'd4, op_a: 8'hFC,  op_b: 8'd2, res: 16'hFFFA};
        mem[2] = '{opc: 4'd5, op_a: 8'd7,   op_b: 8'd6, res: 16'd42};
        run_sweep(0, 3, 1'b0);

        // Divide by zero gives 0; 9 mod 4 is 1, so stored 3 mismatches.
        mem[5] = '{opc: 4'd6, op_a: 8'd9, op_b: 8'd0, res: 16'd0};
        mem[6] = '{opc: 4'd7, op_a: 8'd9, op_b: 8'd4, res: 16'd3};
        run_sweep(5, 2, 1'b0);

        // Address wrap.
        for (int i = 30; i < 34; i++) mem[i % DEPTH] = rand_entry();
        run_sweep(30, 4, 1'b0);

        // Backpressure: entry and pointer hold steady while ready is low.
        fixed_ready = 1'b0;
        repeat (2) @(posedge clk);
        mem[10] = rand_entry();
        mem[11] = rand_entry();
        push_sweep(10, 2);
        issue_start(10, 2);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            if (!seen) fail_now("bp_valid_timeout");
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_addr", out_addr, 10);
            check("bp_read_pointer", read_pointer, 10);
            check("bp_out_iw", out_iw, mem[10]);
            @(negedge clk);
        end
        fixed_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_ready_seen_valid", out_valid, 1'b1);
        @(posedge clk); #2;
        check("bp_accepted", out_valid, 1'b0);
        finish_sweep(2);

        // Zero-length sweep, then a start while busy is ignored.
        run_sweep(7, 0, 1'b0);
        for (int i = 3; i < 9; i++) mem[i] = rand_entry();
        run_sweep(3, 6, 1'b1);

        // Asynchronous reset while holding an entry mid-sweep.
        fixed_ready = 1'b0;
        mem[20] = '{opc: 4'd3, op_a: 8'd1, op_b: 8'd1, res: 16'd5};
        for (int i = 21; i < 30; i++) mem[i] = rand_entry();
        issue_start(20, 10);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            if (!seen) fail_now("rst_test_valid_timeout");
        end
        @(negedge clk);
        check("pre_reset_err_count", err_count, (ref_result(mem[20]) != mem[20].res) ? 1 : 0);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_err_count", err_count, 0);
        sb_q.delete();
        done_err_q.delete();
        done_ent_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        fixed_ready = 1'b1;
        mem[20].res = ref_result(mem[20]);
        run_sweep(20, 1, 1'b0);

        // Randomized sweeps with throttled ready.
        rnd_ready = 1'b1;
        for (int s = 0; s < 40; s++) begin
            int sa, cnt;
            for (int i = 0; i < DEPTH; i++) mem[i] = rand_entry();
            sa  = $urandom_range(0, DEPTH - 1);
            cnt = $urandom_range(0, DEPTH);
            run_sweep(sa, cnt, (cnt >= 3) && ($urandom_range(0, 1) == 1));
        end
        rnd_ready = 1'b0;
        repeat (3) @(posedge clk);
        check("final_scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
